// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: sequences two-word immediates, load-use stalls,
// taken-branch flushes and interrupt entry for the IF/ID and PC registers.
module hazard_sequencer #(
    parameter int REG_ADDR_W   = 3,
    parameter int FLUSH_CYCLES = 1,
    parameter int INT_CYCLES   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_needs_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic                  int_req,
    output logic                  pc_en,
    output logic [1:0]            pc_sel,
    output logic                  stall_ld,
    output logic                  immediate,
    output logic                  flush,
    output logic                  idex_bubble,
    output logic                  int_ack
);

    localparam int MAX_CYCLES = (FLUSH_CYCLES > INT_CYCLES) ? FLUSH_CYCLES : INT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_IMM   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_INT   = 2'd3;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_INT = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [CNT_W-1:0] CNT_ZERO   = 0;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] INT_LOAD   = CNT_W'(INT_CYCLES - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             int_pend;
    logic             ldhz;

    assign ldhz = ex_mem_read &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        pc_en       = 1'b1;
        pc_sel      = SEL_SEQ;
        stall_ld    = 1'b0;
        immediate   = 1'b0;
        flush       = 1'b0;
        idex_bubble = 1'b0;
        int_ack     = 1'b0;
        state_nxt   = state;
        cnt_nxt     = cnt;

        if (rst) begin
            pc_en       = 1'b0;
            flush       = 1'b1;
            idex_bubble = 1'b1;
            state_nxt   = S_RUN;
            cnt_nxt     = CNT_ZERO;
        end else if (ex_branch_taken) begin
            // A taken branch wins in every state, aborting IMM and INT alike.
            flush       = 1'b1;
            idex_bubble = 1'b1;
            pc_sel      = SEL_BR;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = S_FLUSH;
                cnt_nxt   = FLUSH_LOAD;
            end else begin
                state_nxt = S_RUN;
                cnt_nxt   = CNT_ZERO;
            end
        end else begin
            case (state)
                S_RUN: begin
                    if (ldhz) begin
                        stall_ld    = 1'b1;
                        pc_en       = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_needs_imm) begin
                        immediate   = 1'b1;
                        idex_bubble = 1'b1;
                        state_nxt   = S_IMM;
                    end else if (int_pend) begin
                        flush       = 1'b1;
                        idex_bubble = 1'b1;
                        if (INT_CYCLES == 1) begin
                            pc_sel  = SEL_INT;
                            int_ack = 1'b1;
                        end else begin
                            pc_en     = 1'b0;
                            state_nxt = S_INT;
                            cnt_nxt   = INT_LOAD;
                        end
                    end
                end
                S_IMM: begin
                    state_nxt = S_RUN;
                end
                S_FLUSH: begin
                    flush       = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt <= CNT_ONE) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = CNT_ZERO;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                S_INT: begin
                    // The RUN entry cycle is the first of the INT_CYCLES, so the
                    // last INT-state cycle is the one entered with cnt==1.
                    flush       = 1'b1;
                    idex_bubble = 1'b1;
                    if (cnt <= CNT_ONE) begin
                        pc_sel    = SEL_INT;
                        int_ack   = 1'b1;
                        state_nxt = S_RUN;
                        cnt_nxt   = CNT_ZERO;
                    end else begin
                        pc_en   = 1'b0;
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = S_RUN;
                    cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            cnt      <= CNT_ZERO;
            int_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            // A request still high during the ack cycle is consumed by that ack.
            int_pend <= int_ack ? 1'b0 : (int_pend | int_req);
        end
    end

endmodule
